// File: rtl/framebuffer_writer_if.sv
// VRAM write port: the framebuffer writer drives it, the memory side receives it.
interface framebuffer_writer_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_d;

    modport master (output wr_en, output wr_addr, output wr_d);
    modport slave  (input wr_en, input wr_addr, input wr_d);
endinterface

// File: rtl/framebuffer_writer.sv
// Turns a blanking-qualified raster pixel stream into clipped VRAM writes,
// optionally ping-ponging between two frame banks.
module framebuffer_writer #(
    parameter int unsigned WIDTH      = 320,
    parameter int unsigned HEIGHT     = 240,
    parameter int unsigned DW         = 8,
    parameter int unsigned DOUBLE_BUF = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 ce_pix,
    input  logic                 hblank,
    input  logic                 vblank,
    input  logic [DW-1:0]        pix_d,
    framebuffer_writer_if.master vram,
    output logic                 frame_done,
    output logic                 display_bank,
    output logic                 overflow
);
    localparam int unsigned FRAME = WIDTH * HEIGHT;
    localparam int unsigned AW    = $clog2(FRAME * ((DOUBLE_BUF != 0) ? 2 : 1));
    localparam int unsigned XW    = $clog2(WIDTH + 1);
    localparam int unsigned YW    = $clog2(HEIGHT + 1);
    localparam int unsigned LW    = $clog2(FRAME + 1);

    typedef enum logic [1:0] {StSync, StWait, StActive} state_e;

    state_e        state_q, state_d;
    logic          hblank_q, vblank_q;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [LW-1:0] line_base_q, line_base_d;
    logic          write_bank_q, write_bank_d;
    logic          display_bank_q, display_bank_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_d_q, wr_d_d;
    logic          frame_done_q, frame_done_d;
    logic          overflow_q, overflow_d;

    logic          vb_rise, vb_fall, hb_rise, accept, in_range;
    logic [AW-1:0] bank_base;

    assign vb_rise   = vblank & ~vblank_q;
    assign vb_fall   = ~vblank & vblank_q;
    assign hb_rise   = hblank & ~hblank_q;
    assign accept    = (state_q == StActive) & ce_pix & ~hblank & ~vblank;
    assign in_range  = (x_q < XW'(WIDTH)) & (y_q < YW'(HEIGHT));
    assign bank_base = write_bank_q ? AW'(FRAME) : '0;

    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        y_d            = y_q;
        line_base_d    = line_base_q;
        write_bank_d   = write_bank_q;
        display_bank_d = display_bank_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_d_d         = wr_d_q;
        frame_done_d   = 1'b0;
        overflow_d     = 1'b0;

        case (state_q)
            StSync: begin
                if (vb_rise && enable) state_d = StWait;
            end
            StWait: begin
                x_d         = '0;
                y_d         = '0;
                line_base_d = '0;
                if (vb_fall) state_d = StActive;
            end
            StActive: begin
                if (vb_rise) begin
                    frame_done_d   = 1'b1;
                    display_bank_d = write_bank_q;
                    write_bank_d   = (DOUBLE_BUF != 0) ? ~write_bank_q : 1'b0;
                    state_d        = enable ? StWait : StSync;
                end else if (hb_rise && (x_q != '0)) begin
                    // Empty lines leave y alone; y and line_base saturate together.
                    x_d = '0;
                    if (y_q < YW'(HEIGHT)) begin
                        y_d         = y_q + YW'(1);
                        line_base_d = line_base_q + LW'(WIDTH);
                    end
                end else if (accept) begin
                    if (in_range) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = bank_base + AW'(line_base_q) + AW'(x_q);
                        wr_d_d    = pix_d;
                        x_d       = x_q + XW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            default: state_d = StSync;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StSync;
            hblank_q       <= 1'b0;
            vblank_q       <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            line_base_q    <= '0;
            write_bank_q   <= 1'b0;
            display_bank_q <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_d_q         <= '0;
            frame_done_q   <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            hblank_q       <= hblank;
            vblank_q       <= vblank;
            x_q            <= x_d;
            y_q            <= y_d;
            line_base_q    <= line_base_d;
            write_bank_q   <= write_bank_d;
            display_bank_q <= display_bank_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_d_q         <= wr_d_d;
            frame_done_q   <= frame_done_d;
            overflow_q     <= overflow_d;
        end
    end

    assign vram.wr_en   = wr_en_q;
    assign vram.wr_addr = wr_addr_q;
    assign vram.wr_d    = wr_d_q;
    assign frame_done   = frame_done_q;
    assign display_bank = display_bank_q;
    assign overflow     = overflow_q;
endmodule
